// File: rtl/fb_clear_engine.sv
// ---------------------------------------------------------------------------
// fb_clear_engine
//
// Rectangle-fill pixel write generator that services the CLEAR command
// inside gpu_core. A clear walks a width x height region in row-major order
// and emits one framebuffer write per handshake, every write carrying the
// same clear colour. Row start addresses come from adding the stride to the
// previous row start, so the block needs no multiplier.
//
// Ports:
//   clk          block clock, rising edge
//   rst          asynchronous active-high reset
//   start        single-cycle request to begin a clear (sampled in IDLE only)
//   abort        stop after the current handshake (sampled in WRITE only)
//   fb_base      byte address of pixel (0,0)
//   fb_stride    bytes per row, added unsigned
//   fb_width     pixels per row, low DIM_WIDTH bits used
//   fb_height    row count, low DIM_WIDTH bits used
//   clear_color  pixel value written to every location
//   fb_wr_valid  write request valid
//   fb_wr_ready  downstream accepts the request
//   fb_wr_addr   pixel byte address
//   fb_wr_data   pixel data
//   busy         high while writes are being generated
//   done         one-cycle pulse when a clear finishes or is aborted
//   pixel_count  handshakes completed in the current or last clear
// ---------------------------------------------------------------------------
module fb_clear_engine #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DIM_WIDTH       = 16,
    parameter int BYTES_PER_PIXEL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    input  logic [31:0]           fb_stride,
    input  logic [31:0]           fb_width,
    input  logic [31:0]           fb_height,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  fb_wr_valid,
    input  logic                  fb_wr_ready,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [DATA_WIDTH-1:0] fb_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pixel_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } state_t;

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BPP_INC = ADDR_WIDTH'(BYTES_PER_PIXEL);

    state_t                  state;
    state_t                  state_next;

    logic [DIM_WIDTH-1:0]    width_in;
    logic [DIM_WIDTH-1:0]    height_in;
    logic [DIM_WIDTH-1:0]    width_r;
    logic [DIM_WIDTH-1:0]    height_r;
    logic [DIM_WIDTH-1:0]    x_cnt;
    logic [DIM_WIDTH-1:0]    y_cnt;
    logic [ADDR_WIDTH-1:0]   stride_r;
    logic [ADDR_WIDTH-1:0]   row_addr;
    logic [ADDR_WIDTH-1:0]   next_row_addr;

    logic                    handshake;
    logic                    last_col;
    logic                    last_row;

    logic                    load_cmd;
    logic                    clear_count;
    logic                    count_inc;
    logic                    step_col;
    logic                    step_row;

    // Only the low DIM_WIDTH bits of the dimensions matter; the upper bits
    // are deliberately ignored so a driver may leave junk there.
    logic                    unused_dim_bits;

    assign width_in        = fb_width[DIM_WIDTH-1:0];
    assign height_in       = fb_height[DIM_WIDTH-1:0];
    assign unused_dim_bits = ^{fb_width[31:DIM_WIDTH], fb_height[31:DIM_WIDTH]};

    // Valid, busy and done are pure decodes of the state register, so the
    // asynchronous reset clears them in the same instant it clears the state.
    assign fb_wr_valid = (state == WRITE);
    assign busy        = (state == WRITE);
    assign done        = (state == FINISH);

    assign handshake     = fb_wr_valid && fb_wr_ready;
    // width_r/height_r are never zero while in WRITE, so the minus-one
    // compares cannot underflow there.
    assign last_col      = (x_cnt == (width_r - DIM_ONE));
    assign last_row      = (y_cnt == (height_r - DIM_ONE));
    assign next_row_addr = row_addr + stride_r;

    // State register. Everything the FSM decides is computed in the
    // combinational block below; this block only holds the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the datapath strobes. A handshake that arrives
    // together with abort still counts, then the walk stops; abort without a
    // handshake is the one case where a pending request is withdrawn.
    // start is only looked at in IDLE, so a start while busy or finishing is
    // silently dropped.
    always_comb begin
        state_next  = state;
        load_cmd    = 1'b0;
        clear_count = 1'b0;
        count_inc   = 1'b0;
        step_col    = 1'b0;
        step_row    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    clear_count = 1'b1;
                    if ((width_in == '0) || (height_in == '0)) begin
                        state_next = FINISH;
                    end else begin
                        load_cmd   = 1'b1;
                        state_next = WRITE;
                    end
                end
            end

            WRITE: begin
                if (handshake) begin
                    count_inc = 1'b1;
                    if (abort) begin
                        state_next = FINISH;
                    end else if (!last_col) begin
                        step_col = 1'b1;
                    end else if (!last_row) begin
                        step_row = 1'b1;
                    end else begin
                        state_next = FINISH;
                    end
                end else if (abort) begin
                    state_next = FINISH;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. The command is captured once at start so later
    // input changes cannot disturb a clear in flight. The next address is
    // computed and registered on each handshake, which lets the engine issue
    // one write per cycle while holding addr/data steady during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_r     <= '0;
            height_r    <= '0;
            stride_r    <= '0;
            row_addr    <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            pixel_count <= '0;
        end else begin
            if (load_cmd) begin
                width_r    <= width_in;
                height_r   <= height_in;
                stride_r   <= ADDR_WIDTH'(fb_stride);
                row_addr   <= fb_base;
                fb_wr_addr <= fb_base;
                fb_wr_data <= clear_color;
                x_cnt      <= '0;
                y_cnt      <= '0;
            end else if (step_col) begin
                x_cnt      <= x_cnt + DIM_ONE;
                fb_wr_addr <= fb_wr_addr + BPP_INC;
            end else if (step_row) begin
                x_cnt      <= '0;
                y_cnt      <= y_cnt + DIM_ONE;
                row_addr   <= next_row_addr;
                fb_wr_addr <= next_row_addr;
            end

            if (clear_count) begin
                pixel_count <= '0;
            end else if (count_inc) begin
                pixel_count <= pixel_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_clear_engine.sv
// ---------------------------------------------------------------------------
// tb_fb_clear_engine
//
// Bench for fb_clear_engine. A behavioural model turns each accepted start
// into the full list of pixel addresses (base + y*stride + x*bytes) and then
// simply pops that list on every handshake. A compare process checks the
// DUT against the model on every falling edge, and each directed scenario
// pins the model with hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_fb_clear_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] fb_base;
    logic [31:0] fb_stride;
    logic [31:0] fb_width;
    logic [31:0] fb_height;
    logic [31:0] clear_color;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic [31:0] fb_wr_addr;
    logic [31:0] fb_wr_data;
    logic        busy;
    logic        done;
    logic [31:0] pixel_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_busy;
    bit          m_done;
    logic [31:0] m_count;
    logic [31:0] m_data;
    logic [31:0] m_q[$];

    // Observation log filled by the compare process
    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    int          hs_cyc[$];
    int          cyc_cnt    = 0;
    int          done_count = 0;

    localparam logic [31:0] BASIC_COLOR = 32'hFF00FF00;
    logic [31:0] basic_addrs[8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                    32'h1020, 32'h1024, 32'h1028, 32'h102C};

    fb_clear_engine #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .DIM_WIDTH      (16),
        .BYTES_PER_PIXEL(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .fb_base    (fb_base),
        .fb_stride  (fb_stride),
        .fb_width   (fb_width),
        .fb_height  (fb_height),
        .clear_color(clear_color),
        .fb_wr_valid(fb_wr_valid),
        .fb_wr_ready(fb_wr_ready),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .busy       (busy),
        .done       (done),
        .pixel_count(pixel_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a clear is a list of addresses; each handshake
    // removes one; the clear ends when the list empties or abort is seen,
    // followed by a single done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_count = '0;
            m_data  = '0;
            m_q.delete();
        end else if (m_busy) begin
            if (fb_wr_ready) begin
                m_count = m_count + 1;
                void'(m_q.pop_front());
                if (abort || (m_q.size() == 0)) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (abort) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            int w;
            int h;
            w       = int'(fb_width[15:0]);
            h       = int'(fb_height[15:0]);
            m_count = '0;
            m_data  = clear_color;
            m_q.delete();
            for (int yy = 0; yy < h; yy++) begin
                for (int xx = 0; xx < w; xx++) begin
                    m_q.push_back(fb_base + 32'(yy) * fb_stride + 32'(xx) * 32'd4);
                end
            end
            if (m_q.size() == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge, away from the active
    // edge, plus the handshake log used by the directed scenarios.
    always @(negedge clk) begin
        cyc_cnt++;
        checkOutput("valid", fb_wr_valid, m_busy);
        checkOutput("busy", busy, m_busy);
        checkOutput("done", done, m_done);
        checkOutput("pixel_count", pixel_count, m_count);
        if (m_busy) begin
            checkOutput("addr", fb_wr_addr, m_q[0]);
            checkOutput("data", fb_wr_data, m_data);
        end
        if (fb_wr_valid && fb_wr_ready) begin
            hs_addr.push_back(fb_wr_addr);
            hs_data.push_back(fb_wr_data);
            hs_cyc.push_back(cyc_cnt);
        end
        if (done) begin
            done_count++;
        end
    end

    // Runs one clear: pulses start with the given command, then scrambles
    // the command inputs, drives ready at the requested rate and injects
    // abort / a second start as asked, until done or the cycle budget ends.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride,
                                 input logic [31:0] w, input logic [31:0] h,
                                 input logic [31:0] color, input int ready_pct,
                                 input int abort_at, input int abort_pct,
                                 input bit stall_abort, input bit second_start);
        int start_done;
        int cyc;
        start_done = done_count;
        hs_addr.delete();
        hs_data.delete();
        hs_cyc.delete();
        @(posedge clk);
        #1;
        fb_base     = base;
        fb_stride   = stride;
        fb_width    = w;
        fb_height   = h;
        clear_color = color;
        start       = 1'b1;
        abort       = 1'b0;
        cyc         = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start       = 1'b0;
            abort       = 1'b0;
            fb_base     = $urandom();
            fb_stride   = $urandom();
            fb_width    = $urandom();
            fb_height   = $urandom();
            clear_color = $urandom();
            if (stall_abort) begin
                fb_wr_ready = 1'b0;
            end else begin
                fb_wr_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (second_start && (cyc == 2)) begin
                start     = 1'b1;
                fb_base   = 32'hDEAD0000;
                fb_width  = 32'd3;
                fb_height = 32'd3;
            end
            if (stall_abort && (cyc == 3)) begin
                abort = 1'b1;
            end
            if ((abort_at > 0) && m_busy && fb_wr_ready && (m_count == 32'(abort_at - 1))) begin
                abort = 1'b1;
            end
            if ((abort_pct > 0) && ($urandom_range(0, 99) < abort_pct)) begin
                abort = 1'b1;
            end
        end while ((done_count == start_done) && (cyc < 400));
        start = 1'b0;
        abort = 1'b0;
        if (done_count == start_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no_done expected=done within 400 cycles");
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done_pulses", 64'(done_count - start_done), 64'd1);
    endtask

    task automatic checkBasicSequence(input string tag);
        checkOutput({tag, "_writes"}, 64'(hs_addr.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < hs_addr.size()) begin
                checkOutput({tag, "_addr"}, hs_addr[i], basic_addrs[i]);
                checkOutput({tag, "_data"}, hs_data[i], BASIC_COLOR);
            end
        end
        checkOutput({tag, "_pixel_count"}, pixel_count, 64'd8);
    endtask

    initial begin
        int wait_cyc;
        int done_before;
        logic [31:0] rb;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        fb_base     = '0;
        fb_stride   = '0;
        fb_width    = '0;
        fb_height   = '0;
        clear_color = '0;
        fb_wr_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", fb_wr_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_addr", fb_wr_addr, 32'h0);
        checkOutput("reset_data", fb_wr_data, 32'h0);
        checkOutput("reset_pixel_count", pixel_count, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] basic fill");
        applyStimulus(32'h1000, 32, 4, 2, BASIC_COLOR, 100, 0, 0, 1'b0, 1'b0);
        checkBasicSequence("basic");
        if (hs_cyc.size() == 8) begin
            checkOutput("basic_back_to_back", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);
        end

        $display("[TB] backpressure");
        applyStimulus(32'h1000, 32, 4, 2, BASIC_COLOR, 30, 0, 0, 1'b0, 1'b0);
        checkBasicSequence("stall");

        $display("[TB] degenerate sizes");
        applyStimulus(32'h2000, 64, 0, 5, 32'h12345678, 100, 0, 0, 1'b0, 1'b0);
        checkOutput("w0_writes", 64'(hs_addr.size()), 64'd0);
        checkOutput("w0_pixel_count", pixel_count, 64'd0);
        applyStimulus(32'h3000, 64, 1, 1, 32'hCAFEF00D, 100, 0, 0, 1'b0, 1'b0);
        checkOutput("w1h1_writes", 64'(hs_addr.size()), 64'd1);
        if (hs_addr.size() == 1) begin
            checkOutput("w1h1_addr", hs_addr[0], 32'h3000);
            checkOutput("w1h1_data", hs_data[0], 32'hCAFEF00D);
        end
        checkOutput("w1h1_pixel_count", pixel_count, 64'd1);

        $display("[TB] abort");
        applyStimulus(32'h4000, 16, 4, 4, 32'hA5A5A5A5, 100, 6, 0, 1'b0, 1'b0);
        checkOutput("abort6_writes", 64'(hs_addr.size()), 64'd6);
        checkOutput("abort6_pixel_count", pixel_count, 64'd6);
        if (hs_addr.size() == 6) begin
            checkOutput("abort6_last_addr", hs_addr[5], 32'h4014);
        end
        applyStimulus(32'h5000, 16, 4, 4, 32'h5A5A5A5A, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("stall_abort_writes", 64'(hs_addr.size()), 64'd0);
        checkOutput("stall_abort_pixel_count", pixel_count, 64'd0);
        checkOutput("stall_abort_valid", fb_wr_valid, 1'b0);

        $display("[TB] start while busy");
        applyStimulus(32'h1000, 32, 4, 2, BASIC_COLOR, 60, 0, 0, 1'b0, 1'b1);
        checkBasicSequence("restart");

        $display("[TB] reset mid-clear");
        hs_addr.delete();
        @(posedge clk);
        #1;
        fb_base     = 32'h6000;
        fb_stride   = 32'd32;
        fb_width    = 32'd4;
        fb_height   = 32'd4;
        clear_color = 32'h0BADBEEF;
        fb_wr_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_cyc = 0;
        while ((m_count != 32'd3) && (wait_cyc < 50)) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        checkOutput("pre_reset_count", pixel_count, 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", fb_wr_valid, 1'b0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_addr", fb_wr_addr, 32'h0);
        checkOutput("async_data", fb_wr_data, 32'h0);
        checkOutput("async_pixel_count", pixel_count, 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        fb_wr_ready = 1'b0;
        done_before = done_count;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_reset_no_done", 64'(done_count - done_before), 64'd0);
        checkOutput("post_reset_busy", busy, 1'b0);
        applyStimulus(32'h1000, 32, 4, 2, BASIC_COLOR, 100, 0, 0, 1'b0, 1'b0);
        checkBasicSequence("after_reset");

        $display("[TB] randomized clears");
        for (int it = 0; it < 40; it++) begin
            rb = (it % 5 == 0) ? 32'hFFFFFFF0 : ($urandom() & 32'hFFFFFFFC);
            applyStimulus(rb,
                          (it % 3 == 0) ? $urandom() : 32'($urandom_range(0, 64) * 4),
                          32'($urandom_range(0, 5)) | ((it % 4 == 0) ? ($urandom() << 16) : 32'h0),
                          32'($urandom_range(0, 4)) | ((it % 6 == 0) ? ($urandom() << 16) : 32'h0),
                          $urandom(),
                          $urandom_range(20, 100),
                          0,
                          (it % 2 == 0) ? 4 : 0,
                          1'b0, 1'b0);
        end

        // abort while idle must be ignored; the compare process watches it
        @(posedge clk);
        #1;
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("idle_abort_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
